// File: rtl/zap_arb_pkg.sv
// Shared types and default constants for the instruction/data memory arbiter.
package zap_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, DONE} arb_state_e;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF      = 255;

  // Latched bus-side request; the bus outputs come straight from these flops
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } bus_req_t;

endpackage

// File: rtl/zap_mem_arbiter_if.sv
// Port bundle for the arbiter: data port, instruction port and shared bus.
interface zap_mem_arbiter_if;
  logic        i_d_req, i_d_wr;
  logic [31:0] i_d_addr, i_d_wdata;
  logic [3:0]  i_d_sel;
  logic        o_d_ack, o_d_err;
  logic [31:0] o_d_rdata;
  logic        i_i_req;
  logic [31:0] i_i_addr;
  logic        o_i_ack, o_i_err;
  logic [31:0] o_i_rdata;
  logic        o_bus_cyc, o_bus_stb, o_bus_we;
  logic [31:0] o_bus_adr, o_bus_dat;
  logic [3:0]  o_bus_sel;
  logic        i_bus_ack, i_bus_err;
  logic [31:0] i_bus_dat;

  modport slave (
    input  i_d_req, i_d_wr, i_d_addr, i_d_wdata, i_d_sel, i_i_req, i_i_addr,
           i_bus_ack, i_bus_err, i_bus_dat,
    output o_d_ack, o_d_err, o_d_rdata, o_i_ack, o_i_err, o_i_rdata,
           o_bus_cyc, o_bus_stb, o_bus_we, o_bus_adr, o_bus_dat, o_bus_sel
  );

  modport master (
    output i_d_req, i_d_wr, i_d_addr, i_d_wdata, i_d_sel, i_i_req, i_i_addr,
           i_bus_ack, i_bus_err, i_bus_dat,
    input  o_d_ack, o_d_err, o_d_rdata, o_i_ack, o_i_err, o_i_rdata,
           o_bus_cyc, o_bus_stb, o_bus_we, o_bus_adr, o_bus_dat, o_bus_sel
  );
endinterface

// File: rtl/zap_mem_arb_timer.sv
// Bus watchdog: counts enabled cycles, flags the last one before TIMEOUT is hit.
module zap_mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Fires during the TIMEOUT-th enabled cycle so the owner leaves BUSY after exactly TIMEOUT cycles
  assign expired = enable && (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || clear)      cnt <= '0;
    else if (enable && !expired) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/zap_mem_arbiter.sv
// Two-port (data/instruction) to single bus arbiter with starvation guard and bus timeout.
module zap_mem_arbiter
  import zap_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input logic              i_clk,
  input logic              i_reset,
  zap_mem_arbiter_if.slave arb
);
  localparam int SW = $clog2(STARVE_LIMIT + 2);

  arb_state_e  state;
  bus_req_t    breq;
  logic        grant_i;
  logic [SW-1:0] starve;
  logic        busy, bus_done, expired, pick_i, done_err;
  logic [31:0] done_dat;

  assign busy     = (state == BUSY_D) || (state == BUSY_I);
  assign bus_done = arb.i_bus_ack | arb.i_bus_err;
  assign pick_i   = arb.i_i_req && (!arb.i_d_req || starve == SW'(STARVE_LIMIT));
  // Error wins over ack; with neither present we only get here through the timeout
  assign done_err = arb.i_bus_err | ~arb.i_bus_ack;
  assign done_dat = bus_done ? arb.i_bus_dat : 32'h0;

  assign arb.o_bus_cyc = breq.cyc;
  assign arb.o_bus_stb = breq.stb;
  assign arb.o_bus_we  = breq.we;
  assign arb.o_bus_adr = breq.adr;
  assign arb.o_bus_dat = breq.dat;
  assign arb.o_bus_sel = breq.sel;

  zap_mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clear   (!busy),
    .enable  (busy && !bus_done),
    .expired (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      breq          <= '0;
      grant_i       <= 1'b0;
      starve        <= '0;
      arb.o_d_ack   <= 1'b0;
      arb.o_d_err   <= 1'b0;
      arb.o_d_rdata <= '0;
      arb.o_i_ack   <= 1'b0;
      arb.o_i_err   <= 1'b0;
      arb.o_i_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!arb.i_i_req) starve <= '0;
          if (pick_i) begin
            grant_i <= 1'b1;
            starve  <= '0;
            breq    <= '{cyc: 1'b1, stb: 1'b1, we: 1'b0, adr: arb.i_i_addr,
                         dat: 32'h0, sel: 4'hF};
            state   <= BUSY_I;
          end else if (arb.i_d_req) begin
            grant_i <= 1'b0;
            if (arb.i_i_req && starve != SW'(STARVE_LIMIT)) starve <= starve + SW'(1);
            breq    <= '{cyc: 1'b1, stb: 1'b1, we: arb.i_d_wr, adr: arb.i_d_addr,
                         dat: arb.i_d_wdata, sel: arb.i_d_sel};
            state   <= BUSY_D;
          end
        end
        BUSY_D, BUSY_I: begin
          if (bus_done || expired) begin
            breq.cyc <= 1'b0;
            breq.stb <= 1'b0;
            if (grant_i) begin
              arb.o_i_ack   <= 1'b1;
              arb.o_i_err   <= done_err;
              arb.o_i_rdata <= done_dat;
            end else begin
              arb.o_d_ack   <= 1'b1;
              arb.o_d_err   <= done_err;
              arb.o_d_rdata <= done_dat;
            end
            state <= DONE;
          end
        end
        DONE: begin
          arb.o_d_ack <= 1'b0;
          arb.o_d_err <= 1'b0;
          arb.o_i_ack <= 1'b0;
          arb.o_i_err <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/zap_mem_arbiter.md
ZAP_MEM_ARBITER -- requirements
Module: zap_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while an instruction request waits.
REQ-002 SHALL have parameter TIMEOUT, default 255: bus cycles without ack/err before the transaction is aborted.
REQ-003 i_clk  in  1  clock; all logic on rising edge.
REQ-004 i_reset  in  1  reset, synchronous, active-high.
REQ-005 i_d_req, i_d_wr  in  1,1  data-port request, write enable; held high until o_d_ack.
REQ-006 i_d_addr, i_d_wdata, i_d_sel  in  32,32,4  data-port address, write data, byte selects.
REQ-007 o_d_ack, o_d_err, o_d_rdata  out  1,1,32  data-port completion pulse, fault flag, read data.
REQ-008 i_i_req, i_i_addr  in  1,32  instruction-port read request, held until o_i_ack; address.
REQ-009 o_i_ack, o_i_err, o_i_rdata  out  1,1,32  instruction-port completion pulse, fault flag, read data.
REQ-010 o_bus_cyc, o_bus_stb, o_bus_we  out  1,1,1  shared bus cycle, strobe, write.
REQ-011 o_bus_adr, o_bus_dat, o_bus_sel  out  32,32,4  shared bus address, write data, byte selects.
REQ-012 i_bus_ack, i_bus_err, i_bus_dat  in  1,1,32  bus acknowledge, error, read data.

Function
REQ-013 SHALL implement states IDLE, BUSY_D, BUSY_I, DONE.
REQ-014 IDLE: no request -> stay; else grant per REQ-016, latch the port's addr/data/sel/we, enter BUSY_D or BUSY_I next cycle.
REQ-015 BUSY_x: o_bus_cyc=o_bus_stb=1, bus outputs from latched fields; instruction port drives we=0, sel=4'hF.
REQ-016 Priority: data over instruction, except instruction wins when starve counter == STARVE_LIMIT and i_i_req=1.
REQ-017 Starve counter: +1 on a data grant while i_i_req=1; cleared on an instruction grant or in IDLE with i_i_req=0; saturates at STARVE_LIMIT.
REQ-018 BUSY_x with i_bus_ack or i_bus_err: capture i_bus_dat and err, deassert cyc/stb next cycle, enter DONE.
REQ-019 DONE: single cycle with o_x_ack=1 for the granted port only, o_x_rdata = captured data, o_x_err = captured err; then IDLE.
REQ-020 Port requests SHALL NOT be sampled in DONE; an acked requester dropping or re-raising req is arbitrated in the following IDLE cycle.
REQ-021 Minimum latency: req in IDLE cycle N, stb at N+1, ack at N+1 -> o_x_ack at N+2.
REQ-022 Timeout counter cleared on BUSY entry, +1 per BUSY cycle without ack/err; at TIMEOUT -> DONE with err=1, rdata=0.
REQ-023 Simultaneous i_bus_ack and i_bus_err SHALL be treated as error.
REQ-024 o_d_rdata/o_i_rdata SHALL hold their last value outside DONE; o_x_ack/o_x_err are 0 outside DONE.
REQ-025 i_bus_ack/i_bus_err in IDLE or DONE SHALL be ignored.

Reset
REQ-026 On i_reset: state IDLE, starve and timeout counters 0, o_bus_cyc/stb/we 0, o_d_ack/o_i_ack/o_d_err/o_i_err 0, rdata 0, bus adr/dat/sel 0.
REQ-027 Reset mid-transaction SHALL drop cyc/stb on the next edge and generate no ack for the aborted request.

Structure
REQ-028 State enum and default STARVE_LIMIT/TIMEOUT constants SHALL live in shared package zap_arb_pkg.
REQ-029 Timeout counter SHALL be a sub-module zap_mem_arb_timer (inputs clear, enable; output expired).
REQ-030 All outputs SHALL be registered; no combinational path from i_bus_* to port outputs.

Verification
REQ-031 Data read: i_d_req, addr 32'h100, bus ack one cycle after stb with dat 32'hDEADBEEF -> o_d_ack at N+2, o_d_rdata=32'hDEADBEEF, o_d_err=0.
REQ-032 Both ports request together -> data granted first; instruction granted in the IDLE after data DONE.
REQ-033 Data held continuously with i_i_req=1 -> exactly 4 data grants, then one instruction grant, counter 0.
REQ-034 Bus never acks -> o_d_ack with o_d_err=1, rdata 0, exactly 255 BUSY cycles after stb rises.
REQ-035 i_bus_err with write (sel 4'b0011) -> o_d_ack and o_d_err=1, o_bus_we=1 with sel 4'b0011 during BUSY.
REQ-036 i_reset during BUSY_I -> cyc/stb 0 next cycle, no o_i_ack, late i_bus_ack ignored.
